// File: rtl/dmem_dump.sv
// dmem_dump: walks a block of data-memory words starting at a base address
// and streams each word out as bytes, most significant byte first, on a
// valid/ready byte interface feeding the serial transmitter.
module dmem_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // Bytes per word is derived from the word width and cannot be overridden.
  localparam int NBYTES = DATA_W / 8;
  // Keep the byte index at least one bit wide so an 8-bit word still elaborates.
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remain;
  logic [IDX_W-1:0]  idx;
  // Holds the not-yet-presented bytes of the captured word, left-aligned.
  // The byte on out_data is already out of it, so later writes to the same
  // memory word cannot disturb the word being sent.
  logic [DATA_W-1:0] shreg;
  logic              transfer;

  // A byte moves only when it is offered and the transmitter takes it.
  assign transfer = out_valid && out_ready;

  // The address register drives the memory port in every state.
  assign mem_a = addr;

  // Dump sequencer with registered stream and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remain    <= '0;
      idx       <= '0;
      shreg     <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr   <= base;
            remain <= count;
            busy   <= 1'b1;
            // An empty block goes straight to completion without a read.
            state  <= (count == '0) ? FIN : READ;
          end
        end

        READ: begin
          // Capture the whole word now; present its top byte next cycle.
          out_data  <= mem_rd[DATA_W-1 -: 8];
          shreg     <= mem_rd << 8;
          out_valid <= 1'b1;
          idx       <= '0;
          state     <= SEND;
        end

        SEND: begin
          // Without a transfer every stream register simply holds.
          if (transfer) begin
            if (idx != LAST_IDX) begin
              // Next byte follows immediately, no idle cycle in between.
              idx      <= idx + 1'b1;
              out_data <= shreg[DATA_W-1 -: 8];
              shreg    <= shreg << 8;
            end else begin
              out_valid <= 1'b0;
              remain    <= remain - 1'b1;
              // Address arithmetic wraps naturally at the top of the space.
              addr      <= addr + 1'b1;
              state     <= (remain == ADDR_W'(1)) ? FIN : READ;
            end
          end
        end

        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_dump.md
Name: dmem_dump

Overview:
- Read-side counterpart of the data memory. After a start pulse, it walks a block of dmem words from a base address.
- Each 32-bit word is split into bytes, MSB first, and sent on a valid/ready byte stream feeding the board's serial transmitter.
- Used on the FPGA to dump result tables (edge lists, graph data) back to the host after a program run.
- Drives the dmem read port: address out, combinational read data in.

Parameters:
- DATA_W, 32, dmem word width; must be a multiple of 8.
- ADDR_W, 16, dmem word-address width.
- NBYTES, DATA_W/8, bytes per word. Derived; not overridable.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- base  input  ADDR_W  first word address; sampled with start.
- count  input  ADDR_W  number of words to dump; sampled with start.
- mem_a  output  ADDR_W  dmem word address.
- mem_rd  input  DATA_W  dmem read data; combinational from mem_a.
- out_data  output  8  byte to transmitter.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  transmitter accepts the byte this cycle.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is asynchronous and active-high on rst; it takes effect immediately, independent of clk.
- Reset values: state=IDLE, mem_a=0, out_data=0, out_valid=0, busy=0, done=0; internal address, remaining-count and byte-index registers all 0.
- IDLE:
  - On start=1: latch addr<=base and remain<=count.
  - If count==0, go to FIN. Otherwise go to READ.
  - busy goes high in the next cycle in either case.
- READ (1 cycle):
  - mem_a=addr; mem_rd is captured into the shift register at the clock edge.
  - byte index <= 0; go to SEND.
- SEND:
  - out_valid=1; out_data = byte (NBYTES-1-idx) of the captured word, MSB first.
  - Transfer occurs on a cycle with out_valid && out_ready.
  - On a transfer with idx < NBYTES-1: idx++, stay in SEND. The next byte may be presented in the very next cycle; no bubble.
  - On a transfer of the last byte:
    - remain--; addr <= addr+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
    - If remain was 1, go to FIN; else go to READ.
  - Without a transfer, out_data and out_valid hold stable; valid never drops before it is accepted.
- FIN (1 cycle): done=1, busy=0 in the same cycle, then return to IDLE.
- Output rules by state:
  - mem_a shows addr in all states; it is sampled only in READ.
  - out_valid is 0 outside SEND.
- Throughput: 1 READ cycle + NBYTES transfer cycles per word with ready tied high, i.e. 5 cycles/word at 32 bits.
- Latency: with ready high, start at cycle 0 puts the first byte valid at cycle 2.
- Boundary conditions:
  - start while busy (any non-IDLE state): ignored, no effect on the dump in progress.
  - count==0: no bytes sent; done pulses 2 cycles after start.
  - mem_rd changing during SEND (CPU write to the same word): has no effect, because the word was captured in READ.
  - rst asserted mid-dump: out_valid falls immediately (asynchronous) and the dump is abandoned; no done pulse.
  - out_ready high while out_valid is low: ignored.
- Arithmetic: addr and remain are ADDR_W bits, unsigned. Maximum count is 2^ADDR_W-1.

Test Plan:
- Bench dmem model: mem[0]=32'h214a0015, mem[1]=32'h0013000a. start, base=0, count=2, out_ready=1 -> bytes 21,4a,00,15,00,13,00,0a on consecutive valid cycles except one gap cycle between words; done pulses once; busy high for exactly 11 cycles.
- Same dump, out_ready toggling 1,0,0,1,... -> out_data and out_valid hold stable on every ready=0 cycle; byte sequence unchanged; no byte duplicated or dropped.
- count=0, base=5 -> out_valid stays 0; done pulses 2 cycles after start; mem never sampled.
- base=16'hFFFF, count=2, mem[FFFF]=32'h11223344, mem[0]=32'h55667788 -> bytes 11,22,33,44,55,66,77,88; mem_a reads FFFF then 0000.
- Second start, base=9, pulsed mid-dump -> ignored; the original stream completes unchanged and done pulses exactly once.
- rst raised while out_valid=1 on the 3rd byte -> out_valid=0 and busy=0 without waiting for a clock edge, no done; a new start after reset release dumps from the new base correctly.
